mem_access_unit: RTL and testbench

//  Initiator side of the data-memory interface, in the MEM stage of the 5-stage pipeline.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mau_wait_counter.sv | 27 ++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory interface definitions: state encoding and default geometry.
package mem_pkg;

  localparam int unsigned MEM_AW    = 16;
  localparam int unsigned MEM_DW    = 16;
  localparam int unsigned MEM_DEPTH = 16;
  // Wait-state counter width; covers WAIT values 0..15.
  localparam int unsigned WAIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mau_wait_counter.sv
// Wait-state down-counter: load a start value, count down to zero, flag completion.
module mau_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         done_c
);

  // Count register; load has priority over decrement, saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data memory: request/response handshakes,
// wait-state insertion, out-of-range detection and a single-cycle write strobe.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned AW    = MEM_AW,
  parameter int unsigned DW    = MEM_DW,
  parameter int unsigned DEPTH = MEM_DEPTH,
  parameter int unsigned WAIT  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  mau_state_e          state_q, state_d;
  logic                lat_we_q, lat_we_d;
  logic [AW-1:0]       mem_addr_d;
  logic [DW-1:0]       mem_wdata_d;
  logic                mem_we_d;
  logic                rsp_valid_d;
  logic [DW-1:0]       rsp_rdata_d;
  logic                rsp_err_d;
  logic                cnt_load;
  logic                cnt_dec;
  logic [WAIT_W-1:0]   cnt;
  logic                cnt_done_c;
  logic                addr_oor_c;

  mau_wait_counter #(
    .W (WAIT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_W'(WAIT)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .done_c   (cnt_done_c)
  );

  // Full-width range check, no truncation of the request address.
  assign addr_oor_c = (req_addr >= AW'(DEPTH));

  assign req_ready = (state_q == IDLE);
  assign stall     = req_valid & ~req_ready;

  // Next-state and next-register logic. The write strobe is precomputed one
  // cycle early so mem_we comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_oor_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ACCESS;
            lat_we_d    = req_we;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            cnt_load    = 1'b1;
            mem_we_d    = req_we && (WAIT == 0);
          end
        end
      end
      ACCESS: begin
        if (cnt_done_c) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = lat_we_q ? '0 : mem_rdata;
        end else begin
          cnt_dec  = 1'b1;
          mem_we_d = lat_we_q && (cnt == WAIT_W'(1));
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lat_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_we_q  <= lat_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: three units (WAIT = 0, 3, 2), each with its own 16-word data memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        stall     [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic        mem_we    [3];
  logic [15:0] mem_rdata [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rd;
  logic        er;
  int          lat;
  int          w0;
  int          bad;
  logic [15:0] b2b_addr [3] = '{16'd0, 16'd1, 16'd3};
  logic [15:0] b2b_data [3] = '{16'h0000, 16'h0001, 16'h1000};
  int          b2b_cyc  [3] = '{2, 3, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WT = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    logic [15:0] mem [16];
    int          we_cycles = 0;

    mem_access_unit #(
      .AW(16), .DW(16), .DEPTH(16), .WAIT(WT)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .stall     (stall[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_we    (mem_we[g]),
      .mem_rdata (mem_rdata[g])
    );

    // DataMemory model: combinational read, posedge write.
    assign mem_rdata[g] = mem[mem_addr[g][3:0]];

    always @(posedge clk) begin
      if (mem_we[g]) begin
        mem[mem_addr[g][3:0]] <= mem_wdata[g];
        we_cycles <= we_cycles + 1;
      end
    end

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'hA000 | 16'(i);
      mem[0] = 16'h0000;
      mem[1] = 16'h0001;
      mem[2] = 16'h0010;
      mem[3] = 16'h1000;
      mem[7] = 16'h0777;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int we_cnt(input int k);
    case (k)
      0:       return g_dut[0].we_cycles;
      1:       return g_dut[1].we_cycles;
      default: return g_dut[2].we_cycles;
    endcase
  endfunction

  // One full transaction from IDLE: present, accept, wait for response, consume.
  task automatic do_txn(input int k, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output logic err, output int edges);
    @(negedge clk);
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid[k] = 1'b0;
    while (!rsp_valid[k] && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check($sformatf("consume_valid%0d", k), rsp_valid[k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rsp_valid%0d", k), rsp_valid[k], 1'b0);
      check($sformatf("rst_rsp_rdata%0d", k), rsp_rdata[k], 16'h0000);
      check($sformatf("rst_rsp_err%0d", k), rsp_err[k], 1'b0);
      check($sformatf("rst_mem_we%0d", k), mem_we[k], 1'b0);
      check($sformatf("rst_mem_addr%0d", k), mem_addr[k], 16'h0000);
      check($sformatf("rst_req_ready%0d", k), req_ready[k], 1'b1);
    end
    rst = 1'b1;

    // 1: WAIT=0 load addr 2
    do_txn(0, 1'b0, 16'd2, 16'h0000, rd, er, lat);
    check("t1_lat", lat, 2);
    check("t1_rdata", rd, 16'h0010);
    check("t1_err", er, 1'b0);

    // 2: store then load back
    w0 = we_cnt(0);
    do_txn(0, 1'b1, 16'd5, 16'hBEEF, rd, er, lat);
    check("t2_st_lat", lat, 2);
    check("t2_st_rdata", rd, 16'h0000);
    check("t2_st_err", er, 1'b0);
    check("t2_we_cycles", we_cnt(0) - w0, 1);
    check("t2_mem5", g_dut[0].mem[5], 16'hBEEF);
    do_txn(0, 1'b0, 16'd5, 16'h0000, rd, er, lat);
    check("t2_ld_rdata", rd, 16'hBEEF);

    // 3: out-of-range and boundary addresses
    w0 = we_cnt(0);
    do_txn(0, 1'b0, 16'd16, 16'h0000, rd, er, lat);
    check("t3_lat", lat, 1);
    check("t3_err", er, 1'b1);
    check("t3_rdata", rd, 16'h0000);
    do_txn(0, 1'b1, 16'h8005, 16'h1234, rd, er, lat);
    check("t3_hi_err", er, 1'b1);
    check("t3_hi_lat", lat, 1);
    check("t3_we_cycles", we_cnt(0) - w0, 0);
    check("t3_mem5_kept", g_dut[0].mem[5], 16'hBEEF);
    do_txn(0, 1'b0, 16'd15, 16'h0000, rd, er, lat);
    check("t3_last_err", er, 1'b0);
    check("t3_last_rdata", rd, 16'hA00F);

    // 4: WAIT=3, response held, queued request stalls
    @(negedge clk);
    req_we[1]    = 1'b0;
    req_addr[1]  = 16'd3;
    req_valid[1] = 1'b1;
    @(posedge clk);
    lat = 1;
    bad = 0;
    @(negedge clk);
    while (!rsp_valid[1] && lat < 50) begin
      if (!stall[1]) bad++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("t4_lat", lat, 5);
    check("t4_stall_access", bad, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!rsp_valid[1] || rsp_rdata[1] !== 16'h1000 || rsp_err[1] || !stall[1]) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    check("t4_hold", bad, 0);
    check("t4_rdata", rsp_rdata[1], 16'h1000);
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_rsp_cleared", rsp_valid[1], 1'b0);
    check("t4_idle_ready", req_ready[1], 1'b1);
    check("t4_idle_stall", stall[1], 1'b0);
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t4_not_accepted", req_ready[1], 1'b1);

    // 5: reset during a WAIT=2 store at cnt=1
    w0 = we_cnt(2);
    @(negedge clk);
    req_we[2]    = 1'b1;
    req_addr[2]  = 16'd7;
    req_wdata[2] = 16'h5A5A;
    req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_mem_addr", mem_addr[2], 16'd7);
    check("t5_busy", req_ready[2], 1'b0);
    rst = 1'b0;
    #1;
    check("t5_we_in_rst", mem_we[2], 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_mem7", g_dut[2].mem[7], 16'h0777);
    check("t5_we_cycles", we_cnt(2) - w0, 0);
    check("t5_rsp_valid", rsp_valid[2], 1'b0);
    check("t5_rsp_err", rsp_err[2], 1'b0);
    check("t5_rsp_rdata", rsp_rdata[2], 16'h0000);
    check("t5_mem_addr_rst", mem_addr[2], 16'h0000);
    check("t5_mem_wdata_rst", mem_wdata[2], 16'h0000);
    check("t5_req_ready", req_ready[2], 1'b1);
    check("t5_u0_rdata_rst", rsp_rdata[0], 16'h0000);

    // 6: back-to-back loads with req_valid and rsp_ready held high
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_we[0]    = 1'b0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr[0] = b2b_addr[i];
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end while (!rsp_valid[0] && lat < 50);
      check($sformatf("t6_cycles%0d", i), lat, b2b_cyc[i]);
      check($sformatf("t6_rdata%0d", i), rsp_rdata[0], b2b_data[i]);
    end
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check("t6_end_valid", rsp_valid[0], 1'b0);
    check("t6_end_ready", req_ready[0], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
